// File: rtl/key_sw_io.sv
// key_sw_io: memory-mapped KEY/SW input device. Synchronizes and debounces the
// board inputs, latches sticky key presses with overrun flags, raises IRQ.
module key_sw_io #(
  parameter int DBCYCLES = 100000,
  parameter int CW       = 17
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic [15:0] DIN,
  input  logic        WE,
  output logic [15:0] DOUT,
  output logic        SEL,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic        IRQ
);

  localparam logic [15:0]   A_KDATA  = 16'hFFF0;
  localparam logic [15:0]   A_SDATA  = 16'hFFF2;
  localparam logic [15:0]   A_KEDGE  = 16'hFFF4;
  localparam logic [15:0]   A_KCTRL  = 16'hFFF6;
  // bits [3:0] are keys (idle high), bits [13:4] are switches
  localparam logic [13:0]   RST_VAL  = 14'h000F;
  localparam logic [CW-1:0] CNT_LAST = CW'(DBCYCLES - 1);

  logic [13:0]   s1, s2, deb;
  logic [CW-1:0] cnt [14];
  logic [13:0]   upd;
  logic [3:0]    kedge, kovr, ie;
  logic [3:0]    press, clr;
  logic          wr_kedge, wr_kctrl;
  logic          unused_din;

  assign unused_din = ^DIN[15:4];

  always_comb begin
    upd = '0;
    for (int i = 0; i < 14; i++)
      upd[i] = (s2[i] != deb[i]) && (cnt[i] == CNT_LAST);
  end

  // a press is a debounced key falling from 1 to 0
  assign press    = upd[3:0] & deb[3:0];
  assign wr_kedge = WE && (ADDR == A_KEDGE);
  assign wr_kctrl = WE && (ADDR == A_KCTRL);
  assign clr      = wr_kedge ? DIN[3:0] : 4'h0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1  <= RST_VAL;
      s2  <= RST_VAL;
      deb <= RST_VAL;
      for (int i = 0; i < 14; i++) cnt[i] <= '0;
    end else begin
      s1 <= {SW, KEY};
      s2 <= s1;
      for (int i = 0; i < 14; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // a press on the same edge as its clear keeps kedge set but drops kovr
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      kedge <= 4'h0;
      kovr  <= 4'h0;
      ie    <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (press[i]) begin
          kedge[i] <= 1'b1;
          if (clr[i])        kovr[i] <= 1'b0;
          else if (kedge[i]) kovr[i] <= 1'b1;
        end else if (clr[i]) begin
          kedge[i] <= 1'b0;
          kovr[i]  <= 1'b0;
        end
      end
      if (wr_kctrl) ie <= DIN[3:0];
    end
  end

  always_comb begin
    SEL  = 1'b1;
    DOUT = 16'hDEAD;
    case (ADDR)
      A_KDATA: DOUT = {12'h000, deb[3:0]};
      A_SDATA: DOUT = {6'b000000, deb[13:4]};
      A_KEDGE: DOUT = {12'h000, kedge};
      A_KCTRL: DOUT = {8'h00, kovr, ie};
      default: SEL  = 1'b0;
    endcase
  end

  assign IRQ = |(kedge & ie);

endmodule

// File: tb/tb_key_sw_io.sv
// Bench for key_sw_io: bus cycles push expected {SEL,IRQ,DOUT} into a queue that
// a monitor pops each low clock phase; expectations come from a window model.
module tb_key_sw_io;
  localparam int DB = 4;
  localparam int HD = DB + 2;
  localparam logic [13:0] RSTV = 14'h000F;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic [15:0] DIN = 16'h0000;
  logic        WE = 1'b0;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = 10'h155;
  logic [15:0] DOUT;
  logic        SEL;
  logic        IRQ;

  key_sw_io #(.DBCYCLES(DB), .CW(3)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN), .WE(WE),
    .DOUT(DOUT), .SEL(SEL), .KEY(KEY), .SW(SW), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [17:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Model: raw samples per edge; a bit flips once the DB samples that reached
  // the second sync stage all disagree with its current debounced value.
  logic [13:0] hist [HD];
  logic [13:0] deb_m;
  logic [3:0]  kedge_m, kovr_m, ie_m;

  task automatic model_step(input logic rst);
    logic [13:0] nd;
    logic [3:0]  fall, clr_m, old_kedge;
    logic        diff;
    if (rst) begin
      for (int k = 0; k < HD; k++) hist[k] = RSTV;
      deb_m = RSTV; kedge_m = 4'h0; kovr_m = 4'h0; ie_m = 4'h0;
    end else begin
      for (int k = HD - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {SW, KEY};
      nd = deb_m;
      for (int b = 0; b < 14; b++) begin
        diff = 1'b1;
        for (int k = 2; k < HD; k++) if (hist[k][b] == deb_m[b]) diff = 1'b0;
        if (diff) nd[b] = ~deb_m[b];
      end
      fall = deb_m[3:0] & ~nd[3:0];
      clr_m = (WE && ADDR == 16'hFFF4) ? DIN[3:0] : 4'h0;
      old_kedge = kedge_m;
      for (int i = 0; i < 4; i++) begin
        if (fall[i]) begin
          kedge_m[i] = 1'b1;
          kovr_m[i] = clr_m[i] ? 1'b0 : (old_kedge[i] ? 1'b1 : kovr_m[i]);
        end else if (clr_m[i]) begin
          kedge_m[i] = 1'b0;
          kovr_m[i] = 1'b0;
        end
      end
      if (WE && ADDR == 16'hFFF6) ie_m = DIN[3:0];
      deb_m = nd;
    end
  endtask

  always @(posedge CLK or posedge RESET) model_step(RESET);

  function automatic logic [17:0] model_out(input logic [15:0] a);
    logic [15:0] d;
    logic s;
    s = 1'b1;
    d = 16'hDEAD;
    if (a == 16'hFFF0)      d = {12'h000, deb_m[3:0]};
    else if (a == 16'hFFF2) d = {6'b000000, deb_m[13:4]};
    else if (a == 16'hFFF4) d = {12'h000, kedge_m};
    else if (a == 16'hFFF6) d = {8'h00, kovr_m, ie_m};
    else                    s = 1'b0;
    return {s, |(kedge_m & ie_m), d};
  endfunction

  task automatic bus(input logic [15:0] a, input logic w, input logic [15:0] d, input string tag);
    @(negedge CLK);
    ADDR = a; WE = w; DIN = d;
    #1;
    q.push_back('{v: model_out(a), tag: tag});
  endtask

  task automatic bus_k(input logic [15:0] a, input logic w, input logic [15:0] d,
                       input logic [17:0] ev, input string tag);
    @(negedge CLK);
    ADDR = a; WE = w; DIN = d;
    #1;
    q.push_back('{v: ev, tag: tag});
  endtask

  task automatic idle(input int n, input logic [15:0] a);
    for (int j = 0; j < n; j++) bus(a, 1'b0, 16'h0000, "idle");
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({SEL, IRQ, DOUT} !== e.v) begin
          errors++;
          $display("FAIL %s: got sel=%0b irq=%0b dout=%h, need sel=%0b irq=%0b dout=%h",
                   e.tag, SEL, IRQ, DOUT, e.v[17], e.v[16], e.v[15:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [15:0] a;
    logic w;
    model_step(1'b1);
    #1 RESET = 1'b1;

    bus_k(16'hFFF0, 0, 0, {1'b1, 1'b0, 16'h000F}, "rst_kdata");
    bus_k(16'hFFF4, 0, 0, {1'b1, 1'b0, 16'h0000}, "rst_kedge");
    bus_k(16'hFFF6, 0, 0, {1'b1, 1'b0, 16'h0000}, "rst_kctrl");
    bus_k(16'hFFF8, 0, 0, {1'b0, 1'b0, 16'hDEAD}, "rst_unmapped");
    bus_k(16'hFFF2, 0, 0, {1'b1, 1'b0, 16'h0000}, "rst_sdata");
    RESET = 1'b0;
    for (int j = 1; j <= 6; j++)
      bus_k(16'hFFF2, 0, 0, {1'b1, 1'b0, (j < 6) ? 16'h0000 : 16'h0155}, "sw_latency");

    // glitch of three cycles
    KEY[0] = 1'b0;
    repeat (3) bus_k(16'hFFF0, 0, 0, {1'b1, 1'b0, 16'h000F}, "glitch_kdata");
    KEY[0] = 1'b1;
    repeat (6) bus_k(16'hFFF0, 0, 0, {1'b1, 1'b0, 16'h000F}, "glitch_kdata");
    bus_k(16'hFFF4, 0, 0, {1'b1, 1'b0, 16'h0000}, "glitch_kedge");

    // held press
    KEY[0] = 1'b0;
    for (int j = 1; j <= 6; j++)
      bus_k(16'hFFF0, 0, 0, {1'b1, 1'b0, (j < 6) ? 16'h000F : 16'h000E}, "press_latency");
    bus_k(16'hFFF4, 0, 0, {1'b1, 1'b0, 16'h0001}, "press_kedge");
    KEY[0] = 1'b1;
    idle(7, 16'hFFF0);

    // interrupt enable and clear
    bus(16'hFFF4, 1, 16'h0001, "clr0");
    bus(16'hFFF6, 1, 16'h0001, "ie0");
    KEY[0] = 1'b0;
    for (int j = 1; j <= 6; j++)
      bus_k(16'hFFF4, 0, 0, (j < 6) ? {1'b1, 1'b0, 16'h0000} : {1'b1, 1'b1, 16'h0001}, "irq_rise");
    bus_k(16'hFFF4, 1, 16'hFFFE, {1'b1, 1'b1, 16'h0001}, "wr_fffe");
    bus_k(16'hFFF4, 0, 0, {1'b1, 1'b1, 16'h0001}, "after_fffe");
    bus_k(16'hFFF4, 1, 16'h0001, {1'b1, 1'b1, 16'h0001}, "wr_clr_old");
    bus_k(16'hFFF4, 0, 0, {1'b1, 1'b0, 16'h0000}, "irq_drop");
    KEY[0] = 1'b1;
    idle(7, 16'hFFF0);

    // overrun
    bus(16'hFFF6, 1, 16'h0000, "ie_off");
    KEY[2] = 1'b0; idle(7, 16'hFFF4);
    KEY[2] = 1'b1; idle(7, 16'hFFF4);
    KEY[2] = 1'b0; idle(7, 16'hFFF6);
    bus_k(16'hFFF6, 0, 0, {1'b1, 1'b0, 16'h0040}, "ovr_set");
    bus_k(16'hFFF4, 0, 0, {1'b1, 1'b0, 16'h0004}, "ovr_kedge");
    bus(16'hFFF4, 1, 16'h0004, "ovr_clr");
    bus_k(16'hFFF6, 0, 0, {1'b1, 1'b0, 16'h0000}, "ovr_cleared");
    bus_k(16'hFFF4, 0, 0, {1'b1, 1'b0, 16'h0000}, "ovr_kedge_cleared");
    KEY[2] = 1'b1; idle(7, 16'hFFF0);

    // press and clear on the same edge
    KEY[1] = 1'b0; idle(7, 16'hFFF4);
    KEY[1] = 1'b1; idle(7, 16'hFFF4);
    KEY[1] = 1'b0;
    repeat (4) bus(16'hFFF4, 0, 0, "sim_wait");
    bus_k(16'hFFF4, 1, 16'h0002, {1'b1, 1'b0, 16'h0002}, "sim_write");
    bus_k(16'hFFF4, 0, 0, {1'b1, 1'b0, 16'h0002}, "sim_kedge");
    bus_k(16'hFFF6, 0, 0, {1'b1, 1'b0, 16'h0000}, "sim_kovr");
    KEY[1] = 1'b1; idle(7, 16'hFFF0);
    bus(16'hFFF4, 1, 16'h000F, "clr_all");

    // reset in the middle of a debounce
    KEY[3] = 1'b0;
    repeat (3) bus(16'hFFF0, 0, 0, "pre_reset");
    RESET = 1'b1;
    bus_k(16'hFFF0, 0, 0, {1'b1, 1'b0, 16'h000F}, "mid_reset");
    RESET = 1'b0;
    for (int j = 1; j <= 6; j++)
      bus_k(16'hFFF0, 0, 0, {1'b1, 1'b0, (j < 6) ? 16'h000F : 16'h0007}, "post_reset");
    KEY[3] = 1'b1; idle(7, 16'hFFF2);

    // read-only and odd addresses
    bus(16'hFFF0, 1, 16'h1234, "wr_kdata");
    bus(16'hFFF2, 1, 16'hFFFF, "wr_sdata");
    bus_k(16'hFFF0, 0, 0, {1'b1, 1'b0, 16'h000F}, "ro_kdata");
    bus_k(16'hFFF2, 0, 0, {1'b1, 1'b0, 16'h0155}, "ro_sdata");
    bus(16'hFFF6, 1, 16'h0005, "ie5");
    bus(16'hFFF7, 1, 16'h000F, "wr_odd");
    bus_k(16'hFFF6, 0, 0, {1'b1, 1'b0, 16'h0005}, "odd_ie_kept");
    bus_k(16'hFFF7, 0, 0, {1'b0, 1'b0, 16'hDEAD}, "odd_read");

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 13);
        if (r < 4) KEY[r] = ~KEY[r];
        else       SW[r-4] = ~SW[r-4];
      end
      r = $urandom_range(0, 9);
      if (r < 4)      a = 16'hFFF0 + 16'(r * 2);
      else if (r < 7) a = 16'hFFF1 + 16'((r - 4) * 2);
      else            a = 16'($urandom);
      w = ($urandom_range(0, 3) == 0);
      bus(a, w, 16'($urandom), "random");
    end

    @(negedge CLK);
    WE = 1'b0;
    repeat (3) @(negedge CLK);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, need 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_sw_io.md
# key_sw_io

Memory-mapped input device for the 16-bit multicycle processor. It is the responder side of the processor's MAR/WrMem/DrMem I/O accesses in the 0xFFF0–0xFFF6 window. It synchronizes and debounces the board KEY and SW inputs, latches sticky key-press events, and raises a maskable interrupt request. The processor's iomap mux takes `DOUT` directly, and the bus write path drives `DIN`/`WE`.

## Interface
- `DBCYCLES`, default 100000: number of consecutive stable synchronized cycles before a debounced bit updates. Minimum 1. The bench uses 4.
- `CW`, default 17: debounce counter width. Must satisfy 2^CW ≥ DBCYCLES.
- `CLK` in 1: system clock (PLL `c0`).
- `RESET` in 1: asynchronous, active-high reset.
- `ADDR` in 16: MAR value (byte address).
- `DIN` in 16: bus data for writes.
- `WE` in 1: write strobe (WrMem). Sampled on the rising edge of `CLK`.
- `DOUT` out 16: read data. Combinational from `ADDR` and register state.
- `SEL` out 1: high when `ADDR` hits a mapped register of this block.
- `KEY` in 4: raw push buttons. Active-low on the board. Stored uninverted.
- `SW` in 10: raw slide switches.
- `IRQ` out 1: interrupt request, equal to |(KEDGE & IE).

## Operation
- **Register map.** Only even addresses decode. `SEL` = ADDR ∈ {FFF0, FFF2, FFF4, FFF6}.
  - FFF0 KDATA (read-only): {12'b0, kdeb[3:0]}.
  - FFF2 SDATA (read-only): {6'b0, sdeb[9:0]}.
  - FFF4 KEDGE (read / write-1-to-clear): {12'b0, kedge[3:0]}.
  - FFF6 KCTRL: {8'b0, kovr[3:0], ie[3:0]}. `ie` is read/write. `kovr` is read-only.
- **Unselected reads.** When `SEL`=0, `DOUT` = 16'hDEAD.
- **Ignored writes.** Writes to KDATA or SDATA are ignored, as are writes to unmapped or odd addresses. A KCTRL write updates `ie` ← DIN[3:0] only.
- **Synchronizer.** Each of the 14 inputs passes through a 2-flop synchronizer (s1 → s2).
- **Debounce, per bit, one counter each.**
  - If s2 == deb: cnt ← 0.
  - Else if cnt == DBCYCLES−1: deb ← s2 and cnt ← 0.
  - Else: cnt ← cnt+1.
  - A glitch shorter than DBCYCLES synchronized cycles never reaches deb.
- **Press event.** An event on key i is a deb update of kdeb[i] from 1 to 0. On that edge:
  - kedge[i] ← 1.
  - If kedge[i] was already 1 and is not being cleared on the same edge, kovr[i] ← 1.
  - A release (0→1) creates no event.
- **KEDGE write.** Clears each kedge[i] and kovr[i] for which DIN[i]=1.
- **Simultaneous event and clear on the same bit:** the event wins. kedge[i] stays 1, and kovr[i] is cleared rather than set.
- **DOUT timing.** `DOUT` reflects register state before the edge. A read in the same cycle as a write returns the old value.

## Timing
- **Reset values (asynchronous, immediate):**
  - KEY s1/s2/kdeb = 4'hF (released).
  - SW s1/s2/sdeb = 0.
  - All cnt = 0; kedge = 0; kovr = 0; ie = 0.
  - IRQ = 0. DOUT = 16'hDEAD when unselected.
- **Input latency.** A raw input changes before edge k and stays stable. s2 updates at edge k+1, and deb updates at edge k+1+DBCYCLES. So KDATA/SDATA change DBCYCLES+2 edges after the change.
- **Event and IRQ.** kedge sets on the same edge as the kdeb 1→0 update. `IRQ` is combinational, so it rises in that same cycle if ie[i]=1.
- **Write latency.** A write with `WE` high takes effect at that edge. `IRQ` drops in the following cycle when the last enabled kedge bit is cleared.
- **Processor compatibility.** Reads are zero-wait-state, matching the processor's single-cycle DrMem in S_LW4. Writes complete in the S_SW4 cycle.
- **Reset mid-debounce.** RESET asserted mid-debounce discards partial counts. After release, the first update needs a full DBCYCLES+2 edges.
- **Counter wrap.** cnt never exceeds DBCYCLES−1, so no counter wrap is possible.

## Test plan
All scenarios use DBCYCLES=4.
- **Reset.** Assert RESET with KEY=4'hF, SW=10'h155. Read FFF0 → 16'h000F, FFF4 → 0, FFF6 → 0, FFF8 → 16'hDEAD with SEL=0, IRQ=0. Six edges after release, FFF2 → 16'h0155.
- **Debounce and glitch.** Drive KEY[0]=0 for 3 cycles, then 1: KDATA stays 000F and KEDGE stays 0. Drive KEY[0]=0 and hold: KDATA = 000E exactly 6 edges later, and KEDGE = 0001 on that same edge.
- **IRQ and clear.** Write FFF6 ← 0x0001, then press KEY[0]: IRQ=1. Write FFF4 ← 0x0001: KEDGE = 0 and IRQ = 0 the next cycle. Write FFF4 ← 0xFFFE: nothing changes.
- **Overrun.** Press KEY[2], release, press again without clearing: FFF6 reads 0x0040 (kovr[2]) with ie=0. Write FFF4 ← 0x0004: FFF6 → 0x0000 and FFF4 → 0.
- **Simultaneous event and clear.** Schedule a write FFF4 ← 0x0002 on the same edge as the KEY[1] press update: KEDGE = 0x0002 afterward and kovr[1] = 0.
- **Read-only and odd addresses.** Write FFF0 ← 0x1234 and FFF2 ← 0xFFFF: reads unchanged. Write FFF7 ← 0x000F: ie unchanged, and a read of FFF7 gives SEL=0 and 16'hDEAD.
